// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: 1 s tick prescaler, hh/mm set FSM and counter load strobe.
// Optional alarm set/compare path enabled by defining CLK_ALARM_EN.
`timescale 1ns/1ps
module clock_set_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    output logic       ena,
    output logic       load,
    output logic [7:0] load_hh,
    output logic [7:0] load_mm,
    output logic [7:0] load_ss,
    output logic       blink,
`ifdef CLK_ALARM_EN
    output logic       alarm,
    output logic [2:0] state
`else
    output logic [1:0] state
`endif
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

`ifdef CLK_ALARM_EN
    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        COMMIT = 3'd3,
        AL_HH  = 3'd4,
        AL_MM  = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        COMMIT = 2'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic          ena_q, ena_d;
    logic          load_q, load_d;
    logic [7:0]    load_hh_q, load_hh_d;
    logic [7:0]    load_mm_q, load_mm_d;
    logic [7:0]    edit_hh_q, edit_hh_d;
    logic [7:0]    edit_mm_q, edit_mm_d;
`ifdef CLK_ALARM_EN
    logic [7:0]    al_hh_q, al_hh_d;
    logic [7:0]    al_mm_q, al_mm_d;
    logic          al_on_q, al_on_d;
    logic          alarm_q, alarm_d;
`endif

    // Packed-BCD increment with wrap at max (23 for hours, 59 for minutes).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic is_edit(input state_t s);
`ifdef CLK_ALARM_EN
        return (s == SET_HH) || (s == SET_MM) || (s == AL_HH) || (s == AL_MM);
`else
        return (s == SET_HH) || (s == SET_MM);
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            presc_q   <= '0;
            bcnt_q    <= '0;
            blink_q   <= 1'b0;
            ena_q     <= 1'b0;
            load_q    <= 1'b0;
            load_hh_q <= 8'h00;
            load_mm_q <= 8'h00;
            edit_hh_q <= 8'h00;
            edit_mm_q <= 8'h00;
`ifdef CLK_ALARM_EN
            al_hh_q   <= 8'h00;
            al_mm_q   <= 8'h00;
            al_on_q   <= 1'b0;
            alarm_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            blink_q   <= blink_d;
            ena_q     <= ena_d;
            load_q    <= load_d;
            load_hh_q <= load_hh_d;
            load_mm_q <= load_mm_d;
            edit_hh_q <= edit_hh_d;
            edit_mm_q <= edit_mm_d;
`ifdef CLK_ALARM_EN
            al_hh_q   <= al_hh_d;
            al_mm_q   <= al_mm_d;
            al_on_q   <= al_on_d;
            alarm_q   <= alarm_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        bcnt_d    = bcnt_q;
        blink_d   = blink_q;
        ena_d     = 1'b0;
        load_d    = 1'b0;
        load_hh_d = load_hh_q;
        load_mm_d = load_mm_q;
        edit_hh_d = edit_hh_q;
        edit_mm_d = edit_mm_q;
`ifdef CLK_ALARM_EN
        al_hh_d   = al_hh_q;
        al_mm_d   = al_mm_q;
        al_on_d   = al_on_q;
        alarm_d   = 1'b0;
`endif

        // Button handling: mode always takes priority over inc.
        case (state_q)
            RUN: begin
                if (mode_btn) begin
`ifdef CLK_ALARM_EN
                    if (inc_btn) begin
                        state_d = AL_HH;
                    end else begin
                        edit_hh_d = cur_hh;
                        edit_mm_d = cur_mm;
                        state_d   = SET_HH;
                    end
`else
                    edit_hh_d = cur_hh;
                    edit_mm_d = cur_mm;
                    state_d   = SET_HH;
`endif
                end
`ifdef CLK_ALARM_EN
                else if (inc_btn) begin
                    al_on_d = ~al_on_q;
                end
`endif
            end
            SET_HH: begin
                if (mode_btn) begin
                    state_d = SET_MM;
                end else if (inc_btn) begin
                    edit_hh_d = bcd_inc(edit_hh_q, 8'h23);
                end
            end
            SET_MM: begin
                if (mode_btn) begin
                    state_d = COMMIT;
                end else if (inc_btn) begin
                    edit_mm_d = bcd_inc(edit_mm_q, 8'h59);
                end
            end
            COMMIT: begin
                state_d = RUN;
            end
`ifdef CLK_ALARM_EN
            AL_HH: begin
                if (mode_btn) begin
                    state_d = AL_MM;
                end else if (inc_btn) begin
                    al_hh_d = bcd_inc(al_hh_q, 8'h23);
                end
            end
            AL_MM: begin
                if (mode_btn) begin
                    state_d = RUN;
                end else if (inc_btn) begin
                    al_mm_d = bcd_inc(al_mm_q, 8'h59);
                end
            end
`endif
            default: begin
                state_d = RUN;
            end
        endcase

        // Prescaler runs only in RUN and restarts from zero after a commit.
        if (state_q == COMMIT) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = (presc_q == TW'(TICK_DIV - 1)) ? '0 : presc_q + TW'(1);
        end
        ena_d = (state_d == RUN) && (presc_d == TW'(TICK_DIV - 1));

        // Blink restarts high on every entry into an edit state.
        if (is_edit(state_d)) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
                bcnt_d  = '0;
            end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                blink_d = ~blink_q;
                bcnt_d  = '0;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
            end
        end else begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end

        if (state_d == COMMIT) begin
            load_d    = 1'b1;
            load_hh_d = edit_hh_q;
            load_mm_d = edit_mm_q;
        end

`ifdef CLK_ALARM_EN
        alarm_d = (state_d == RUN) && al_on_d && (cur_hh == al_hh_d) && (cur_mm == al_mm_d);
`endif
    end

    assign state   = state_q;
    assign ena     = ena_q;
    assign load    = load_q;
    assign load_hh = load_hh_q;
    assign load_mm = load_mm_q;
    assign load_ss = 8'h00;
    assign blink   = blink_q;
`ifdef CLK_ALARM_EN
    assign alarm   = alarm_q;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (TICK_DIV=4, BLINK_DIV=2).
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic       ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       blink;
`ifdef CLK_ALARM_EN
    logic       alarm;
    logic [2:0] state;
`else
    logic [1:0] state;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .cur_hh   (cur_hh),
        .cur_mm   (cur_mm),
        .ena      (ena),
        .load     (load),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
        .blink    (blink),
`ifdef CLK_ALARM_EN
        .alarm    (alarm),
`endif
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    // Full set sequence; leaves the bench in the COMMIT cycle after checking the load.
    task automatic do_edit(input logic [7:0] h, input logic [7:0] m, input int nh, input int nm,
                           input logic [7:0] exp_h, input logic [7:0] exp_m);
        cur_hh = h;
        cur_mm = m;
        pulse(1'b1, 1'b0);
        check_eq("enter_set_hh", 32'(state), 32'd1);
        check_eq("no_ena_entry", 32'(ena), 32'd0);
        for (int k = 0; k < nh; k++) begin
            pulse(1'b0, 1'b1);
            check_eq("ena_in_set_hh", 32'(ena), 32'd0);
        end
        pulse(1'b1, 1'b0);
        check_eq("enter_set_mm", 32'(state), 32'd2);
        for (int k = 0; k < nm; k++) begin
            pulse(1'b0, 1'b1);
            check_eq("ena_in_set_mm", 32'(ena), 32'd0);
        end
        pulse(1'b1, 1'b0);
        check_eq("enter_commit", 32'(state), 32'd3);
        check_eq("commit_load", 32'(load), 32'd1);
        check_eq("commit_load_hh", 32'(load_hh), 32'(exp_h));
        check_eq("commit_load_mm", 32'(load_mm), 32'(exp_m));
        check_eq("commit_load_ss", 32'(load_ss), 32'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bexp;
        logic       load_seen;

        reset    = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cur_hh   = 8'h00;
        cur_mm   = 8'h00;
        step();
        step();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ena", 32'(ena), 32'd0);
        check_eq("rst_load", 32'(load), 32'd0);
        check_eq("rst_load_hh", 32'(load_hh), 32'h00);
        check_eq("rst_load_mm", 32'(load_mm), 32'h00);
        check_eq("rst_load_ss", 32'(load_ss), 32'h00);
        check_eq("rst_blink", 32'(blink), 32'd0);

        // Free-running: prescaler reaches 3 on the third edge after release.
        reset = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            check_eq("run_ena", 32'(ena), 32'((i % 4) == 3));
            check_eq("run_state", 32'(state), 32'd0);
            check_eq("run_blink", 32'(blink), 32'd0);
            check_eq("run_load", 32'(load), 32'd0);
        end

        // 13:47 -> hh+3, mm+13 -> 16:00; first tick four cycles after COMMIT.
        do_edit(8'h13, 8'h47, 3, 13, 8'h16, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("post_commit_ena", 32'(ena), 32'(k == 4));
            check_eq("post_commit_load", 32'(load), 32'd0);
        end
        check_eq("load_hh_hold", 32'(load_hh), 32'h16);
        check_eq("load_mm_hold", 32'(load_mm), 32'h00);

        do_edit(8'h23, 8'h59, 1, 1, 8'h00, 8'h00);
        step();
        check_eq("wrap_back_run", 32'(state), 32'd0);
        do_edit(8'h09, 8'h39, 1, 1, 8'h10, 8'h40);
        step();
        check_eq("carry_back_run", 32'(state), 32'd0);

        // mode+inc in SET_HH: move on, hours untouched; then blink cadence in SET_MM.
        cur_hh = 8'h05;
        cur_mm = 8'h00;
        pulse(1'b1, 1'b0);
        check_eq("simul_set_hh", 32'(state), 32'd1);
        pulse(1'b1, 1'b1);
        check_eq("simul_set_mm", 32'(state), 32'd2);
        check_eq("blink_entry", 32'(blink), 32'd1);
        bexp = 4'b1001;
        for (int j = 1; j <= 4; j++) begin
            step();
            check_eq("blink_toggle", 32'(blink), 32'(bexp[j-1]));
            check_eq("ena_edit_idle", 32'(ena), 32'd0);
        end
        pulse(1'b1, 1'b0);
        check_eq("simul_commit", 32'(state), 32'd3);
        check_eq("simul_load_hh", 32'(load_hh), 32'h05);
        check_eq("simul_load_mm", 32'(load_mm), 32'h00);
        step();
        check_eq("simul_commit_blink", 32'(blink), 32'd0);

`ifndef CLK_ALARM_EN
        pulse(1'b0, 1'b1);
        check_eq("inc_ignored_run", 32'(state), 32'd0);
`endif

        // Reset mid-edit abandons the edit.
        cur_hh = 8'h12;
        cur_mm = 8'h34;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check_eq("pre_reset_state", 32'(state), 32'd2);
        reset = 1'b0;
        #1;
        check_eq("midrst_state", 32'(state), 32'd0);
        check_eq("midrst_load", 32'(load), 32'd0);
        check_eq("midrst_load_hh", 32'(load_hh), 32'h00);
        check_eq("midrst_load_mm", 32'(load_mm), 32'h00);
        check_eq("midrst_blink", 32'(blink), 32'd0);
        check_eq("midrst_ena", 32'(ena), 32'd0);
        step();
        reset = 1'b1;
        load_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            load_seen = load_seen | load;
            check_eq("post_rst_state", 32'(state), 32'd0);
        end
        check_eq("post_rst_no_load", 32'(load_seen), 32'd0);

`ifdef CLK_ALARM_EN
        // Alarm 07:30 via the mode+inc path, then arm it from RUN.
        cur_hh = 8'h00;
        cur_mm = 8'h00;
        pulse(1'b1, 1'b1);
        check_eq("al_enter_hh", 32'(state), 32'd4);
        repeat (7) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check_eq("al_enter_mm", 32'(state), 32'd5);
        repeat (30) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check_eq("al_back_run", 32'(state), 32'd0);
        check_eq("al_no_load", 32'(load), 32'd0);
        check_eq("al_off", 32'(alarm), 32'd0);
        pulse(1'b0, 1'b1);
        cur_hh = 8'h07;
        cur_mm = 8'h30;
        step();
        check_eq("alarm_match", 32'(alarm), 32'd1);
        cur_mm = 8'h31;
        step();
        check_eq("alarm_nomatch", 32'(alarm), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
